counter_checker: RTL and testbench
==================================

# counter_checker

Receive-side companion to the parameterized counter: it consumes a stream of counter values and confirms they follow the programmed sequence. The sequence is COUNT_FROM, stepping by STEP, wrapping after COUNT_TO. The block acquires lock, flags each out-of-sequence word, keeps a saturating error tally and drops lock on sustained mismatch. It sits at the far end of a datapath, link or FIFO under test, fed by a counter used as a pattern source.

## Interface
- DATA_WIDTH, 8: width of checked word.
- COUNT_FROM, 0: first value of sequence, loaded after wrap.
- COUNT_TO, 255: last value of sequence; must be reachable from COUNT_FROM by repeated STEP.
- STEP, 1: signed increment; negative means down-count.
- LOCK_COUNT, 4: consecutive in-sequence words (seed included) required to lock; ≥2.
- UNLOCK_COUNT, 2: consecutive mismatches while locked that drop lock; ≥1.
- ERR_WIDTH, 16: width of error counter.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  din valid this cycle; en=0 cycles are ignored entirely.
- din  in  DATA_WIDTH  received counter value.
- clr_count  in  1  clear err_count.
- locked  out  1  registered lock status.
- err  out  1  one-cycle pulse per mismatching word while locked.
- err_count  out  ERR_WIDTH  saturating count of err pulses.
- expected  out  DATA_WIDTH  value the next valid word must equal.

## Operation
- next(v): returns COUNT_FROM if v == COUNT_TO. Otherwise returns (v + STEP) mod 2^DATA_WIDTH. STEP is sign-extended; the sum is truncated to DATA_WIDTH.
- States: HUNT, SYNC, LOCKED. Internal good_cnt and bad_cnt are sized to hold LOCK_COUNT and UNLOCK_COUNT.
- HUNT, on en:
  - expected ← next(din).
  - good_cnt ← 1.
  - Go to SYNC.
- SYNC, on en with din == expected:
  - expected ← next(din).
  - good_cnt++.
  - If good_cnt+1 == LOCK_COUNT: go to LOCKED, bad_cnt ← 0.
- SYNC, on en with a mismatch:
  - Reseed: expected ← next(din), good_cnt ← 1.
  - Stay in SYNC.
  - No err.
- LOCKED, on en with a match:
  - expected ← next(din).
  - bad_cnt ← 0.
- LOCKED, on en with a mismatch:
  - err pulse.
  - err_count increments, saturating at all-ones.
  - expected ← next(expected), i.e. flywheel, no reseed.
  - bad_cnt++.
  - If bad_cnt+1 == UNLOCK_COUNT: go to HUNT, locked clears.
- locked = (state == LOCKED), registered.
- clr_count:
  - Sets err_count to 0.
  - If asserted in the same cycle as an error increment, err_count becomes 1; no error is lost.
- en=0:
  - State, counters and expected hold.
  - err = 0.
- Reset (rst=0), regardless of state, including mid-lock:
  - state ← HUNT.
  - locked ← 0, err ← 0, err_count ← 0.
  - expected ← COUNT_FROM.
  - good_cnt ← 0, bad_cnt ← 0.
  - Reset has priority over en and clr_count.

## Timing
- All outputs are registered. Each reflects the word sampled on edge N at edge N+1.
- err is high for exactly one cycle per mismatching word. Back-to-back mismatches give back-to-back pulses.
- locked rises one cycle after the LOCK_COUNT-th consecutive matching word is sampled.
- locked falls one cycle after the UNLOCK_COUNT-th consecutive mismatch. That final mismatch also pulses err.
- expected is valid one cycle after each sampled word.
- No combinational path from inputs to outputs.

## Structure
- Shared package counter_pkg:
  - State encoding constants HUNT/SYNC/LOCKED.
  - The next(v) wrap/step function, parameterized by width, COUNT_FROM, COUNT_TO and STEP, so the generator and checker share one definition of the sequence.
- One sub-module, sat_counter: ERR_WIDTH saturating incrementer with clear, using clr-then-increment semantics. It is instantiated for err_count.
- FSM and comparator live in counter_checker itself.

## Test plan
All scenarios use DATA_WIDTH=8, COUNT_FROM=0, COUNT_TO=9, STEP=1, LOCK_COUNT=4, UNLOCK_COUNT=2, unless stated otherwise.
- Reset: hold rst=0 for 3 cycles with en=1, din=5 → locked=0, err=0, err_count=0, expected=0 throughout.
- Lock acquisition: din 3,4,5,6 on consecutive en cycles → locked=1 one cycle after 6 sampled, expected=7, err never asserted. Repeat with en=0 gaps between words → same result, lock delayed by the gaps only.
- Wrap: locked, din 8,9,0,1 → no err, expected=2.
- Single error with flywheel: locked, expected=2, din 2,7,4 → err pulses one cycle after 7, err_count=1, locked stays 1, then 4 matches with no err.
- Lock loss: locked, din 5,0,0 (expected 5) → two err pulses, err_count +2, locked=0 one cycle after second 0. Next valid word reseeds in HUNT.
- Edge cases:
  - clr_count asserted in the same cycle as a mismatch → err_count=1.
  - ERR_WIDTH=2 with 5 errors → err_count=3.
  - STEP=-2, COUNT_FROM=8, COUNT_TO=0, din 8,6,4,2,0,8 → lock, wrap, no err.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared counter sequence definition and checker state encoding
package counter_pkg;

   localparam int MAX_WIDTH = 64;

   typedef logic [MAX_WIDTH-1:0] word_t;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Successor of v in the sequence; wraps to count_from after count_to, else adds the
   // sign-extended step modulo 2^width. Callers truncate the result to their own width.
   function automatic word_t seq_next(input word_t v, input int unsigned width,
                                      input word_t count_from, input word_t count_to,
                                      input int step);
      word_t mask;
      word_t step_ext;
      word_t sum;
      mask     = (width >= MAX_WIDTH) ? '1 : ((word_t'(1) << width) - word_t'(1));
      step_ext = word_t'(longint'(step));
      sum      = (v + step_ext) & mask;
      if ((v & mask) == (count_to & mask))
         return count_from & mask;
      return sum;
   endfunction

endpackage

// File: rtl/counter_checker_if.sv
// rtl/counter_checker_if.sv - received-word stream and status bundle for counter_checker
interface counter_checker_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ERR_WIDTH  = 16
);
   logic                  en;
   logic [DATA_WIDTH-1:0] din;
   logic                  clr_count;
   logic                  locked;
   logic                  err;
   logic [ERR_WIDTH-1:0]  err_count;
   logic [DATA_WIDTH-1:0] expected;

   modport master (
      output en, din, clr_count,
      input  locked, err, err_count, expected
   );

   modport slave (
      input  en, din, clr_count,
      output locked, err, err_count, expected
   );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter; clear wins but a same-cycle event still counts
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= WIDTH'(inc);
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - locks onto a counter pattern stream, flags and tallies out-of-sequence words
module counter_checker
   import counter_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int COUNT_FROM   = 0,
   parameter int COUNT_TO     = 255,
   parameter int STEP         = 1,
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 2,
   parameter int ERR_WIDTH    = 16
) (
   input logic             clk,
   input logic             rst,
   counter_checker_if.slave bus
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(UNLOCK_COUNT + 1);
   localparam logic [GW-1:0] LOCK_LAST   = GW'(LOCK_COUNT - 1);
   localparam logic [BW-1:0] UNLOCK_LAST = BW'(UNLOCK_COUNT - 1);
   localparam logic [DATA_WIDTH-1:0] FROM_W = DATA_WIDTH'(COUNT_FROM);
   localparam word_t FROM_WORD = word_t'(longint'(COUNT_FROM));
   localparam word_t TO_WORD   = word_t'(longint'(COUNT_TO));

   state_t                state_q, state_n;
   logic [DATA_WIDTH-1:0] exp_q, exp_n;
   logic [GW-1:0]         good_q, good_n;
   logic [BW-1:0]         bad_q, bad_n;
   logic                  err_n, err_q, locked_q;
   logic                  match;
   logic [DATA_WIDTH-1:0] nxt_din, nxt_exp;
   logic [ERR_WIDTH-1:0]  err_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= HUNT;
         exp_q    <= FROM_W;
         good_q   <= '0;
         bad_q    <= '0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_n;
         exp_q    <= exp_n;
         good_q   <= good_n;
         bad_q    <= bad_n;
         err_q    <= err_n;
         locked_q <= (state_n == LOCKED);
      end
   end

   always_comb begin
      nxt_din = DATA_WIDTH'(seq_next(word_t'(bus.din), DATA_WIDTH, FROM_WORD, TO_WORD, STEP));
      nxt_exp = DATA_WIDTH'(seq_next(word_t'(exp_q), DATA_WIDTH, FROM_WORD, TO_WORD, STEP));
      match   = (bus.din == exp_q);
      state_n = state_q;
      exp_n   = exp_q;
      good_n  = good_q;
      bad_n   = bad_q;
      err_n   = 1'b0;
      if (bus.en) begin
         unique case (state_q)
            HUNT: begin
               exp_n   = nxt_din;
               good_n  = GW'(1);
               state_n = SYNC;
            end
            SYNC: begin
               exp_n = nxt_din;
               if (match) begin
                  good_n = good_q + GW'(1);
                  if (good_q == LOCK_LAST) begin
                     state_n = LOCKED;
                     bad_n   = '0;
                  end
               end else begin
                  good_n = GW'(1);
               end
            end
            LOCKED: begin
               if (match) begin
                  exp_n = nxt_din;
                  bad_n = '0;
               end else begin
                  // Flywheel on our own prediction so a single corrupt word costs one error
                  exp_n = nxt_exp;
                  err_n = 1'b1;
                  bad_n = bad_q + BW'(1);
                  if (bad_q == UNLOCK_LAST)
                     state_n = HUNT;
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   sat_counter #(
      .WIDTH (ERR_WIDTH)
   ) u_err_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.clr_count),
      .inc   (err_n),
      .count (err_count)
   );

   assign bus.locked    = locked_q;
   assign bus.err       = err_q;
   assign bus.err_count = err_count;
   assign bus.expected  = exp_q;

endmodule

// File: tb/tb_counter_checker.sv
// tb/tb_counter_checker.sv - directed vector table plus corner sequences for counter_checker
module tb_counter_checker;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   counter_checker_if #(.DATA_WIDTH(8), .ERR_WIDTH(16)) if_a ();
   counter_checker_if #(.DATA_WIDTH(8), .ERR_WIDTH(2))  if_b ();
   counter_checker_if #(.DATA_WIDTH(8), .ERR_WIDTH(16)) if_c ();

   counter_checker #(.DATA_WIDTH(8), .COUNT_FROM(0), .COUNT_TO(9), .STEP(1),
      .LOCK_COUNT(4), .UNLOCK_COUNT(2), .ERR_WIDTH(16))
      dut_a (.clk(clk), .rst(rst), .bus(if_a));

   counter_checker #(.DATA_WIDTH(8), .COUNT_FROM(0), .COUNT_TO(9), .STEP(1),
      .LOCK_COUNT(4), .UNLOCK_COUNT(2), .ERR_WIDTH(2))
      dut_b (.clk(clk), .rst(rst), .bus(if_b));

   counter_checker #(.DATA_WIDTH(8), .COUNT_FROM(8), .COUNT_TO(0), .STEP(-2),
      .LOCK_COUNT(4), .UNLOCK_COUNT(2), .ERR_WIDTH(16))
      dut_c (.clk(clk), .rst(rst), .bus(if_c));

   typedef struct {
      logic        r;
      logic        en;
      logic [7:0]  din;
      logic        clr;
      logic        locked;
      logic        err;
      logic [15:0] cnt;
      logic [7:0]  exp;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic add(input logic r, input logic en, input logic [7:0] din, input logic clr,
                      input logic locked, input logic err, input logic [15:0] cnt,
                      input logic [7:0] exp);
      vec_t v;
      v.r = r; v.en = en; v.din = din; v.clr = clr;
      v.locked = locked; v.err = err; v.cnt = cnt; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   // Drive one word into the selected instance (others idle), then sample just after the edge
   task automatic step(input int sel, input logic r, input logic en, input logic [7:0] din,
                       input logic clr);
      rst = r;
      if_a.en = 1'b0; if_a.din = '0; if_a.clr_count = 1'b0;
      if_b.en = 1'b0; if_b.din = '0; if_b.clr_count = 1'b0;
      if_c.en = 1'b0; if_c.din = '0; if_c.clr_count = 1'b0;
      case (sel)
         0: begin if_a.en = en; if_a.din = din; if_a.clr_count = clr; end
         1: begin if_b.en = en; if_b.din = din; if_b.clr_count = clr; end
         default: begin if_c.en = en; if_c.din = din; if_c.clr_count = clr; end
      endcase
      @(posedge clk);
      #1;
   endtask

   initial begin
      int e;
      rst = 1'b0;
      step(0, 1'b0, 1'b0, 8'd0, 1'b0);

      // r en din clr | locked err cnt expected
      for (int i = 0; i < 3; i++) add(0, 1, 5, 0, 0, 0, 0, 0);
      add(1, 1, 3, 0, 0, 0, 0, 4);
      add(1, 1, 4, 0, 0, 0, 0, 5);
      add(1, 1, 5, 0, 0, 0, 0, 6);
      add(1, 1, 6, 0, 1, 0, 0, 7);
      add(1, 1, 7, 0, 1, 0, 0, 8);
      add(1, 1, 8, 0, 1, 0, 0, 9);
      add(1, 1, 9, 0, 1, 0, 0, 0);
      add(1, 1, 0, 0, 1, 0, 0, 1);
      add(1, 1, 1, 0, 1, 0, 0, 2);
      add(1, 1, 2, 0, 1, 0, 0, 3);
      add(1, 1, 7, 0, 1, 1, 1, 4);
      add(1, 1, 4, 0, 1, 0, 1, 5);
      add(1, 0, 99, 0, 1, 0, 1, 5);
      add(1, 1, 5, 0, 1, 0, 1, 6);
      add(1, 1, 0, 0, 1, 1, 2, 7);
      add(1, 1, 0, 0, 0, 1, 3, 8);
      add(1, 1, 3, 0, 0, 0, 3, 4);
      add(1, 1, 7, 0, 0, 0, 3, 8);
      add(1, 1, 8, 0, 0, 0, 3, 9);
      add(1, 1, 9, 0, 0, 0, 3, 0);
      add(1, 1, 0, 0, 1, 0, 3, 1);
      add(1, 1, 5, 1, 1, 1, 1, 2);
      add(1, 1, 2, 0, 1, 0, 1, 3);
      add(1, 0, 0, 1, 1, 0, 0, 3);
      add(0, 1, 3, 0, 0, 0, 0, 0);
      add(1, 1, 3, 0, 0, 0, 0, 4);
      add(1, 0, 3, 0, 0, 0, 0, 4);
      add(1, 1, 4, 0, 0, 0, 0, 5);
      add(1, 0, 4, 0, 0, 0, 0, 5);
      add(1, 1, 5, 0, 0, 0, 0, 6);
      add(1, 0, 5, 0, 0, 0, 0, 6);
      add(1, 1, 6, 0, 1, 0, 0, 7);

      foreach (vecs[i]) begin
         step(0, vecs[i].r, vecs[i].en, vecs[i].din, vecs[i].clr);
         check($sformatf("v%0d locked", i), if_a.locked, vecs[i].locked);
         check($sformatf("v%0d err", i), if_a.err, vecs[i].err);
         check($sformatf("v%0d err_count", i), if_a.err_count, vecs[i].cnt);
         check($sformatf("v%0d expected", i), if_a.expected, vecs[i].exp);
      end

      // Two-bit error counter saturates at 3 after five isolated errors
      step(1, 1'b0, 1'b0, 8'd0, 1'b0);
      for (int d = 0; d < 4; d++) step(1, 1'b1, 1'b1, 8'(d), 1'b0);
      check("b lock", if_b.locked, 1);
      check("b expected", if_b.expected, 4);
      e = 4;
      for (int k = 1; k <= 5; k++) begin
         step(1, 1'b1, 1'b1, 8'd99, 1'b0);
         check($sformatf("b err%0d", k), if_b.err, 1);
         check($sformatf("b count%0d", k), if_b.err_count, (k > 3) ? 3 : k);
         e = (e == 9) ? 0 : e + 1;
         step(1, 1'b1, 1'b1, 8'(e), 1'b0);
         check($sformatf("b match%0d err", k), if_b.err, 0);
         check($sformatf("b match%0d locked", k), if_b.locked, 1);
         e = (e == 9) ? 0 : e + 1;
      end
      check("b final count", if_b.err_count, 3);

      // Down-count by 2 from 8 to 0, wrapping back to 8
      step(2, 1'b0, 1'b0, 8'd0, 1'b0);
      check("c reset expected", if_c.expected, 8);
      step(2, 1'b1, 1'b1, 8'd8, 1'b0);
      check("c exp after 8", if_c.expected, 6);
      step(2, 1'b1, 1'b1, 8'd6, 1'b0);
      step(2, 1'b1, 1'b1, 8'd4, 1'b0);
      check("c not yet locked", if_c.locked, 0);
      step(2, 1'b1, 1'b1, 8'd2, 1'b0);
      check("c locked", if_c.locked, 1);
      check("c exp after 2", if_c.expected, 0);
      step(2, 1'b1, 1'b1, 8'd0, 1'b0);
      check("c wrap expected", if_c.expected, 8);
      check("c wrap err", if_c.err, 0);
      step(2, 1'b1, 1'b1, 8'd8, 1'b0);
      check("c post-wrap expected", if_c.expected, 6);
      check("c post-wrap err", if_c.err, 0);
      check("c err_count", if_c.err_count, 0);
      check("c still locked", if_c.locked, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
